// File: rtl/trace_reg_pkg.sv
// Shared register map and constants for the trace match-rule register file.
// Holds the block select code, register offsets and the hit-counter width.
package trace_reg_pkg;

    // Block select code compared against reg_address[7:6]
    localparam logic [1:0] TRACE_REG_SELECT = 2'b01;

    // Register offsets within the block (reg_address[5:0])
    localparam logic [5:0] REG_RULE_SEL            = 6'h10;
    localparam logic [5:0] REG_RULE_PATTERN        = 6'h11;
    localparam logic [5:0] REG_RULE_MASK           = 6'h12;
    localparam logic [5:0] REG_RULE_COUNT          = 6'h13;
    localparam logic [5:0] REG_RULE_COMMIT         = 6'h14;
    localparam logic [5:0] REG_COUNT_CLEAR         = 6'h15;
    localparam logic [5:0] REG_STAT                = 6'h16;
    localparam logic [5:0] REG_PATTERN_ENABLE      = 6'h17;
    localparam logic [5:0] REG_PATTERN_TRIG_ENABLE = 6'h18;
    localparam logic [5:0] REG_NUM_RULES           = 6'h19;

    // Per-rule hit counter width
    localparam int TRACE_CNT_W = 16;

    // Bit positions inside REG_STAT
    localparam int STAT_OVERFLOW_BIT = 0;
    localparam int STAT_DIRTY_BIT    = 1;

endpackage

// File: rtl/trace_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Ports: clk_i, rst_ni (async low), clr_i, inc_i, count_o[pWIDTH-1:0].
module trace_sat_counter #(
    parameter int pWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [pWIDTH-1:0] count_o
);

    logic [pWIDTH-1:0] cnt_q;
    logic [pWIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + pWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/trace_rule_regfile.sv
// Trace match-rule register file: shadow/active pattern, mask and enable
// registers with atomic commit, status flags and optional hit counters.
// Ports: usb_clk, reset_n (async low); register bus reg_address,
// reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid -> read_data,
// selected; I_match_hit, I_swo_cdc_overflow; O_pattern_flat, O_mask_flat,
// O_pattern_enable, O_pattern_trig_enable, O_commit.
// Build option: define TRACE_RULE_COUNTERS_EN to build the hit counters.
module trace_rule_regfile
    import trace_reg_pkg::*;
#(
    parameter int pMATCH_RULES  = 8,
    parameter int pBUFFER_SIZE  = 64,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic [7:0]                           reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic                                 selected,
    input  logic [pMATCH_RULES-1:0]              I_match_hit,
    input  logic                                 I_swo_cdc_overflow,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_pattern_flat,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_mask_flat,
    output logic [pMATCH_RULES-1:0]              O_pattern_enable,
    output logic [pMATCH_RULES-1:0]              O_pattern_trig_enable,
    output logic                                 O_commit
);

    localparam int NR = pMATCH_RULES;
    localparam int NB = pBUFFER_SIZE / 8;

    typedef logic [NR-1:0][pBUFFER_SIZE-1:0] rule_arr_t;

    // ---------------- bus decode ----------------
    logic       sel;
    logic [5:0] off;
    logic       wr_en;
    logic       rd_en;
    logic       wr_commit;

    assign sel       = reg_addrvalid && (reg_address[7:6] == TRACE_REG_SELECT);
    assign off       = reg_address[5:0];
    assign wr_en     = sel && reg_write;
    assign rd_en     = sel && reg_read;
    assign wr_commit = wr_en && (off == REG_RULE_COMMIT);
    assign selected  = sel;

    // ---------------- state ----------------
    rule_arr_t       pat_sh_q,  pat_sh_d;
    rule_arr_t       mask_sh_q, mask_sh_d;
    rule_arr_t       pat_act_q, pat_act_d;
    rule_arr_t       mask_act_q, mask_act_d;
    logic [NR-1:0]   en_sh_q,   en_sh_d;
    logic [NR-1:0]   trig_sh_q, trig_sh_d;
    logic [NR-1:0]   en_act_q,  en_act_d;
    logic [NR-1:0]   trig_act_q, trig_act_d;
    logic [7:0]      rule_sel_q, rule_sel_d;
    logic            dirty_q,   dirty_d;
    logic            sticky_q,  sticky_d;
    logic            commit_q;
    logic [7:0]      read_data_q, read_data_d;
    logic [7:0]      rd_val;

    // ---------------- hit counters ----------------
`ifdef TRACE_RULE_COUNTERS_EN
    logic                             wr_clear;
    logic [NR-1:0][TRACE_CNT_W-1:0]   cnt;

    assign wr_clear = wr_en && (off == REG_COUNT_CLEAR);

    for (genvar r = 0; r < NR; r++) begin : g_cnt
        trace_sat_counter #(
            .pWIDTH (TRACE_CNT_W)
        ) u_cnt (
            .clk_i   (usb_clk),
            .rst_ni  (reset_n),
            .clr_i   (wr_clear),
            .inc_i   (I_match_hit[r]),
            .count_o (cnt[r])
        );
    end
`else
    logic unused_hit;
    assign unused_hit = ^I_match_hit;
`endif

    // ---------------- shadow / active next state ----------------
    always_comb begin
        pat_sh_d   = pat_sh_q;
        mask_sh_d  = mask_sh_q;
        en_sh_d    = en_sh_q;
        trig_sh_d  = trig_sh_q;
        rule_sel_d = rule_sel_q;
        dirty_d    = dirty_q;
        sticky_d   = sticky_q;

        if (wr_en) begin
            case (off)
                REG_RULE_SEL: rule_sel_d = write_data;
                REG_RULE_PATTERN, REG_RULE_MASK: begin
                    for (int r = 0; r < NR; r++) begin
                        for (int b = 0; b < NB; b++) begin
                            if (rule_sel_q == 8'(r) &&
                                reg_bytecnt == pBYTECNT_SIZE'(b)) begin
                                if (off == REG_RULE_PATTERN) begin
                                    pat_sh_d[r][b*8 +: 8] = write_data;
                                end else begin
                                    mask_sh_d[r][b*8 +: 8] = write_data;
                                end
                                dirty_d = 1'b1;
                            end
                        end
                    end
                end
                REG_PATTERN_ENABLE, REG_PATTERN_TRIG_ENABLE: begin
                    // Byte n of the register covers rules 8n..8n+7
                    for (int i = 0; i < NR; i++) begin
                        if (reg_bytecnt == pBYTECNT_SIZE'(i / 8)) begin
                            if (off == REG_PATTERN_ENABLE) begin
                                en_sh_d[i] = write_data[i % 8];
                            end else begin
                                trig_sh_d[i] = write_data[i % 8];
                            end
                            dirty_d = 1'b1;
                        end
                    end
                end
                REG_STAT: begin
                    if (write_data[STAT_OVERFLOW_BIT]) sticky_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (wr_commit) dirty_d = 1'b0;
        // A new overflow pulse wins over a same-cycle clear
        if (I_swo_cdc_overflow) sticky_d = 1'b1;
    end

    // A commit cannot coincide with a shadow write, so the current
    // shadow contents are exactly what gets published.
    always_comb begin
        pat_act_d  = pat_act_q;
        mask_act_d = mask_act_q;
        en_act_d   = en_act_q;
        trig_act_d = trig_act_q;
        if (wr_commit) begin
            pat_act_d  = pat_sh_q;
            mask_act_d = mask_sh_q;
            en_act_d   = en_sh_q;
            trig_act_d = trig_sh_q;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_val = '0;
        case (off)
            REG_RULE_SEL: rd_val = rule_sel_q;
            REG_RULE_PATTERN, REG_RULE_MASK: begin
                for (int r = 0; r < NR; r++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (rule_sel_q == 8'(r) &&
                            reg_bytecnt == pBYTECNT_SIZE'(b)) begin
                            if (off == REG_RULE_PATTERN) begin
                                rd_val = pat_sh_q[r][b*8 +: 8];
                            end else begin
                                rd_val = mask_sh_q[r][b*8 +: 8];
                            end
                        end
                    end
                end
            end
`ifdef TRACE_RULE_COUNTERS_EN
            REG_RULE_COUNT: begin
                for (int r = 0; r < NR; r++) begin
                    for (int b = 0; b < TRACE_CNT_W / 8; b++) begin
                        if (rule_sel_q == 8'(r) &&
                            reg_bytecnt == pBYTECNT_SIZE'(b)) begin
                            rd_val = cnt[r][b*8 +: 8];
                        end
                    end
                end
            end
`endif
            REG_STAT: begin
                rd_val[STAT_OVERFLOW_BIT] = sticky_q;
                rd_val[STAT_DIRTY_BIT]    = dirty_q;
            end
            REG_PATTERN_ENABLE, REG_PATTERN_TRIG_ENABLE: begin
                for (int i = 0; i < NR; i++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(i / 8)) begin
                        if (off == REG_PATTERN_ENABLE) begin
                            rd_val[i % 8] = en_sh_q[i];
                        end else begin
                            rd_val[i % 8] = trig_sh_q[i];
                        end
                    end
                end
            end
            REG_NUM_RULES: rd_val = 8'(NR);
            default: ;
        endcase
    end

    assign read_data_d = rd_en ? rd_val : 8'h00;

    // ---------------- registers ----------------
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_sh_q    <= '0;
            mask_sh_q   <= '1;
            pat_act_q   <= '0;
            mask_act_q  <= '1;
            en_sh_q     <= '0;
            trig_sh_q   <= '0;
            en_act_q    <= '0;
            trig_act_q  <= '0;
            rule_sel_q  <= '0;
            dirty_q     <= 1'b0;
            sticky_q    <= 1'b0;
            commit_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            pat_sh_q    <= pat_sh_d;
            mask_sh_q   <= mask_sh_d;
            pat_act_q   <= pat_act_d;
            mask_act_q  <= mask_act_d;
            en_sh_q     <= en_sh_d;
            trig_sh_q   <= trig_sh_d;
            en_act_q    <= en_act_d;
            trig_act_q  <= trig_act_d;
            rule_sel_q  <= rule_sel_d;
            dirty_q     <= dirty_d;
            sticky_q    <= sticky_d;
            commit_q    <= wr_commit;
            read_data_q <= read_data_d;
        end
    end

    assign O_pattern_flat        = pat_act_q;
    assign O_mask_flat           = mask_act_q;
    assign O_pattern_enable      = en_act_q;
    assign O_pattern_trig_enable = trig_act_q;
    assign O_commit              = commit_q;
    assign read_data             = read_data_q;

endmodule
